// File: rtl/ras_pkg.sv
// ras_pkg: shared types and default widths for the checkpointed return-address stack
package ras_pkg;
   localparam int DEF_RAS_SIZE   = 16;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_CKPT_NUM   = 8;
   localparam int PTR_W          = $clog2(DEF_RAS_SIZE);
   localparam int DEP_W          = PTR_W + 1;
   localparam int ID_W           = $clog2(DEF_CKPT_NUM);
   typedef logic [DEF_DATA_WIDTH-1:0] addr_t;
   typedef logic [PTR_W-1:0]          ptr_t;
   typedef logic [DEP_W-1:0]          dep_t;
   typedef struct packed {
      ptr_t  ptr;
      dep_t  depth;
      logic  ovf;
      addr_t top;
   } ras_ckpt_t;
endpackage

// File: rtl/ras_ckpt_file.sv
// ras_ckpt_file: checkpoint register file, one write port and one asynchronous read port
module ras_ckpt_file
   import ras_pkg::*;
#(
   parameter int N    = DEF_CKPT_NUM,
   parameter int IW   = $clog2(N)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  ras_ckpt_t     wdata,
   input  logic [IW-1:0] raddr,
   output ras_ckpt_t     rdata
);
   ras_ckpt_t slot [N];
   // slot storage; cleared on reset so checkpoints never outlive it
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) for (int i = 0; i < N; i++) slot[i] <= '0;
      else if (we) slot[waddr] <= wdata;
   end
   assign rdata = slot[raddr];
endmodule

// File: rtl/ras_ckpt.sv
// ras_ckpt: circular return-address stack with caller-indexed checkpoint/restore
module ras_ckpt
   import ras_pkg::*;
#(
   parameter int RAS_SIZE   = DEF_RAS_SIZE,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CKPT_NUM   = DEF_CKPT_NUM
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        push,
   input  logic [DATA_WIDTH-1:0]       push_pc,
   input  logic                        pop,
   output logic [DATA_WIDTH-1:0]       top_pc,
   output logic                        top_valid,
   input  logic                        ckpt_en,
   input  logic [$clog2(CKPT_NUM)-1:0] ckpt_id,
   input  logic                        restore_en,
   input  logic [$clog2(CKPT_NUM)-1:0] restore_id,
   output logic                        overflowed
);
   localparam dep_t FULL = dep_t'(RAS_SIZE);
   addr_t     stack [RAS_SIZE];
   ptr_t      ptr, ptr_n, wa;
   dep_t      depth, dep_n;
   logic      ovf, ovf_n, we;
   addr_t     wd;
   ras_ckpt_t rd, snap;
   // next state; every stack write lands on the next top, so the snapshot top is the write data when writing
   always_comb begin
      ptr_n = ptr;
      dep_n = depth;
      ovf_n = ovf;
      we    = 1'b0;
      wa    = ptr;
      wd    = push_pc;
      if (restore_en) begin
         ptr_n = rd.ptr;
         dep_n = rd.depth;
         ovf_n = rd.ovf;
         we    = 1'b1;
         wa    = rd.ptr;
         wd    = rd.top;
      end else if (push && (!pop || depth == '0)) begin
         ptr_n = ptr + 1'b1;
         dep_n = (depth == FULL) ? depth : depth + 1'b1;
         ovf_n = ovf | (depth == FULL);
         we    = 1'b1;
         wa    = ptr + 1'b1;
      end else if (push && pop) begin
         we    = 1'b1;
      end else if (pop && depth != '0) begin
         ptr_n = ptr - 1'b1;
         dep_n = depth - 1'b1;
      end
      snap = '{ptr: ptr_n, depth: dep_n, ovf: ovf_n, top: we ? wd : stack[ptr_n]};
   end
   // stack pointer, depth and sticky overflow registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr   <= '1;
         depth <= '0;
         ovf   <= 1'b0;
      end else begin
         ptr   <= ptr_n;
         depth <= dep_n;
         ovf   <= ovf_n;
      end
   end
   // stack entries as flops so restore can write while the slot is read
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) for (int i = 0; i < RAS_SIZE; i++) stack[i] <= '0;
      else if (we) stack[wa] <= wd;
   end
   ras_ckpt_file #(.N(CKPT_NUM)) u_file (
      .clk    (clk),
      .resetn (resetn),
      .we     (ckpt_en),
      .waddr  (ckpt_id),
      .wdata  (snap),
      .raddr  (restore_id),
      .rdata  (rd)
   );
   assign top_pc     = stack[ptr];
   assign top_valid  = depth != '0;
   assign overflowed = ovf;
endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: directed self-checking bench for ras_ckpt
module tb_ras_ckpt;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        push = 1'b0, pop = 1'b0, ckpt_en = 1'b0, restore_en = 1'b0;
   logic [31:0] push_pc = '0;
   logic [2:0]  ckpt_id = '0, restore_id = '0;
   logic [31:0] top_pc;
   logic        top_valid, overflowed;
   int          errors = 0, checks = 0;
   always #5 clk = ~clk;
   ras_ckpt dut (
      .clk        (clk),
      .resetn     (resetn),
      .push       (push),
      .push_pc    (push_pc),
      .pop        (pop),
      .top_pc     (top_pc),
      .top_valid  (top_valid),
      .ckpt_en    (ckpt_en),
      .ckpt_id    (ckpt_id),
      .restore_en (restore_en),
      .restore_id (restore_id),
      .overflowed (overflowed)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic p, input logic [31:0] pc, input logic po,
                       input logic ce, input logic [2:0] cid, input logic re, input logic [2:0] rid);
      push = p; push_pc = pc; pop = po; ckpt_en = ce; ckpt_id = cid; restore_en = re; restore_id = rid;
      @(posedge clk); #1;
      push = 0; pop = 0; ckpt_en = 0; restore_en = 0;
   endtask
   task automatic do_push(input logic [31:0] pc); step(1, pc, 0, 0, 0, 0, 0); endtask
   task automatic do_pop();                       step(0, 0, 1, 0, 0, 0, 0); endtask
   task automatic do_reset();
      resetn = 0;
      @(posedge clk); #1;
      resetn = 1;
   endtask
   initial begin
      @(posedge clk); #1;
      chk("rst_top", top_pc, 0);
      chk("rst_valid", top_valid, 0);
      chk("rst_ovf", overflowed, 0);
      chk("rst_depth", dut.depth, 0);
      resetn = 1;
      do_push(32'h100); do_push(32'h200); do_push(32'h300);
      chk("p3_top", top_pc, 32'h300);
      chk("p3_depth", dut.depth, 3);
      do_pop(); chk("pop1_top", top_pc, 32'h200);
      do_pop(); chk("pop2_top", top_pc, 32'h100);
      do_pop(); chk("pop3_valid", top_valid, 0);
      do_pop(); chk("underflow_depth", dut.depth, 0);
      for (int i = 0; i < 17; i++) do_push(32'h1000 + 4 * i);
      chk("ovf_flag", overflowed, 1);
      chk("ovf_depth", dut.depth, 16);
      for (int i = 16; i >= 1; i--) begin
         chk($sformatf("ovf_pop%0d", i), top_pc, 32'h1000 + 4 * i);
         do_pop();
      end
      chk("ovf_empty", top_valid, 0);
      chk("ovf_sticky", overflowed, 1);
      step(0, 0, 0, 0, 0, 1, 0);
      chk("rest_clr_ovf", overflowed, 0);
      chk("rest_clr_depth", dut.depth, 0);
      do_reset();
      do_push(32'hA0);
      step(1, 32'hB0, 1, 0, 0, 0, 0);
      chk("pp_top", top_pc, 32'hB0);
      chk("pp_depth", dut.depth, 1);
      do_pop();
      step(1, 32'hC0, 1, 0, 0, 0, 0);
      chk("pp_empty_top", top_pc, 32'hC0);
      chk("pp_empty_depth", dut.depth, 1);
      do_reset();
      do_push(32'h10); do_push(32'h20);
      step(0, 0, 0, 1, 3, 0, 0);
      do_pop(); do_push(32'h99); do_push(32'h77);
      chk("pre_rest_top", top_pc, 32'h77);
      step(0, 0, 0, 0, 0, 1, 3);
      chk("rest_top", top_pc, 32'h20);
      chk("rest_depth", dut.depth, 2);
      do_pop();
      chk("rest_pop_top", top_pc, 32'h10);
      step(1, 32'h55, 0, 0, 0, 1, 3);
      chk("rest_push_top", top_pc, 32'h20);
      chk("rest_push_depth", dut.depth, 2);
      step(0, 0, 0, 1, 5, 1, 3);
      do_push(32'hEE); do_push(32'hFF);
      chk("pre_rest5_depth", dut.depth, 4);
      step(0, 0, 0, 0, 0, 1, 5);
      chk("rest5_top", top_pc, 32'h20);
      chk("rest5_depth", dut.depth, 2);
      step(1, 32'h44, 0, 1, 6, 0, 0);
      do_pop(); do_pop();
      chk("pre_rest6_top", top_pc, 32'h10);
      step(0, 0, 0, 0, 0, 1, 6);
      chk("rest6_top", top_pc, 32'h44);
      chk("rest6_depth", dut.depth, 3);
      do_pop();
      chk("rest6_pop_top", top_pc, 32'h20);
      do_push(32'h1); do_push(32'h2); do_push(32'h3);
      chk("d5_depth", dut.depth, 5);
      chk("d5_top", top_pc, 32'h3);
      #2 resetn = 0;
      #1;
      chk("async_top", top_pc, 0);
      chk("async_valid", top_valid, 0);
      chk("async_depth", dut.depth, 0);
      @(posedge clk); #1;
      resetn = 1;
      step(0, 0, 0, 0, 0, 1, 3);
      chk("post_rst_rest3_depth", dut.depth, 0);
      chk("post_rst_rest3_top", top_pc, 0);
      step(0, 0, 0, 0, 0, 1, 6);
      chk("post_rst_rest6_valid", top_valid, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
